servo_move_sequencer: RTL

//  Queues timed robot moves (direction + duration in ms) and plays them back
//  on the direction/useServo inputs of ServoController, one after another.

---
 rtl/servo_move_sequencer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/servo_move_sequencer.sv
// servo_move_sequencer
//   Queues timed robot moves (direction + duration in ms) and plays them back
//   one after another on the direction/useServo inputs of ServoController.
//   Game logic posts a whole dance sequence into the command FIFO and moves on.
//
// Ports
//   clk         system clock, rising edge
//   resetn      asynchronous active-low reset
//   cmd_valid   command offered
//   cmd_ready   FIFO can accept (not full and no abort)
//   cmd_dir     direction code (000 stop, 001 fwd, 010 back, 011 left, 100 right)
//   cmd_ms      move duration in ms, 0 = discard
//   abort       flush the queue and stop now
//   direction   registered direction to ServoController
//   useServo    registered 1-cycle load strobe to ServoController
//   move_done   1-cycle pulse when a move's duration expires
//   busy        high while the sequencer is not idle or the FIFO holds entries
//   fifo_count  number of queued commands
//
// Build option
//   SERVO_SEQ_GAP_EN : insert a stop interval of GAP_MS ms between moves.
//                      Undefined: consecutive moves run back-to-back.
//
// States
//   IDLE | waiting; pops the head entry when the FIFO is not empty
//   RUN  | move in progress, ms prescaler and remaining-ms counter active
//   DONE | move just expired; reload from FIFO or stop (gap build: start gap)
//   GAP  | stop interval between moves (gap build only)

module servo_move_sequencer #(
    parameter int DEPTH        = 8,
    parameter int MS_W         = 12,
    parameter int TICKS_PER_MS = 50000,
    parameter int GAP_MS       = 20
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_dir,
    input  logic [MS_W-1:0]          cmd_ms,
    input  logic                     abort,
    output logic [2:0]               direction,
    output logic                     useServo,
    output logic                     move_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PS_W  = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int ENT_W = 3 + MS_W;
`ifdef SERVO_SEQ_GAP_EN
    localparam int GAP_CYC = GAP_MS * TICKS_PER_MS;
    localparam int GAP_W   = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
`ifdef SERVO_SEQ_GAP_EN
        ,
        S_GAP  = 2'd3
`endif
    } state_t;

    // ---------------- command FIFO ----------------
    logic [ENT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [2:0]       head_dir;
    logic [MS_W-1:0]  head_ms;

    state_t           state;
    logic             abort_q;
    logic [PS_W-1:0]  prescaler;
    logic [MS_W-1:0]  remaining;
    logic             ps_wrap;
`ifdef SERVO_SEQ_GAP_EN
    logic [GAP_W-1:0] gap_cnt;
`endif

    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign cmd_ready  = !full && !abort;
    assign push       = cmd_valid && cmd_ready;
    assign {head_dir, head_ms} = mem[rd_ptr];
    assign fifo_count = count;
    assign busy       = (state != S_IDLE) || !empty;
    assign ps_wrap    = (prescaler == PS_W'(TICKS_PER_MS - 1));

    // The FSM consumes the head in IDLE, and in DONE only when moves chain
    // back-to-back. Zero-ms heads are popped the same way and simply ignored.
    always_comb begin
        pop = 1'b0;
        if (!abort && !empty) begin
            case (state)
                S_IDLE:  pop = 1'b1;
`ifndef SERVO_SEQ_GAP_EN
                S_DONE:  pop = 1'b1;
`endif
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_dir, cmd_ms};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            abort_q   <= 1'b0;
            prescaler <= '0;
            remaining <= '0;
            direction <= 3'b000;
            useServo  <= 1'b0;
            move_done <= 1'b0;
`ifdef SERVO_SEQ_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            useServo  <= 1'b0;
            move_done <= 1'b0;
            abort_q   <= abort;
            if (abort) begin
                state     <= S_IDLE;
                prescaler <= '0;
                remaining <= '0;
`ifdef SERVO_SEQ_GAP_EN
                gap_cnt   <= '0;
`endif
                // A held abort stops the servo once, not every cycle.
                if (!abort_q) begin
                    direction <= 3'b000;
                    useServo  <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!empty && head_ms != '0) begin
                            direction <= head_dir;
                            useServo  <= 1'b1;
                            prescaler <= '0;
                            remaining <= head_ms;
                            state     <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (ps_wrap) begin
                            prescaler <= '0;
                            if (remaining != '0) remaining <= remaining - 1'b1;
                            if (remaining == MS_W'(1)) begin
                                move_done <= 1'b1;
                                state     <= S_DONE;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                    S_DONE: begin
`ifdef SERVO_SEQ_GAP_EN
                        // The entry strobe counts as the first gap cycle and the
                        // IDLE pop cycle as the last, so the counter covers the rest.
                        direction <= 3'b000;
                        useServo  <= 1'b1;
                        gap_cnt   <= GAP_W'(GAP_CYC - 2);
                        state     <= S_GAP;
`else
                        if (!empty) begin
                            if (head_ms != '0) begin
                                direction <= head_dir;
                                useServo  <= 1'b1;
                                prescaler <= '0;
                                remaining <= head_ms;
                                state     <= S_RUN;
                            end
                        end else begin
                            direction <= 3'b000;
                            useServo  <= 1'b1;
                            state     <= S_IDLE;
                        end
`endif
                    end
`ifdef SERVO_SEQ_GAP_EN
                    S_GAP: begin
                        if (gap_cnt == '0) begin
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
